// File: rtl/rsa_core_arbiter.sv
// Round-robin arbiter sharing one RSA modexp core between two requesters.
// Latches the granted operands, sequences the core and routes the result back.
module rsa_core_arbiter #(
  parameter int KEY_W = 1024,
  parameter int CNT_W = 32
) (
  input  logic             avm_clk,
  input  logic             avm_rst,
  input  logic [1:0]       req,
  input  logic [KEY_W-1:0] req_msg0,
  input  logic [KEY_W-1:0] req_key0,
  input  logic [KEY_W-1:0] req_n0,
  input  logic [KEY_W-1:0] req_msg1,
  input  logic [KEY_W-1:0] req_key1,
  input  logic [KEY_W-1:0] req_n1,
  output logic [1:0]       req_ack,
  output logic [1:0]       rsp_valid,
  output logic [KEY_W-1:0] rsp_ans,
  output logic [CNT_W-1:0] rsp_cycles,
  output logic             busy,
  output logic             owner,
  output logic             core_start,
  output logic [KEY_W-1:0] core_msg,
  output logic [KEY_W-1:0] core_key,
  output logic [KEY_W-1:0] core_n,
  input  logic [KEY_W-1:0] core_ans,
  input  logic             core_finished,
  output logic [1:0]       state_dbg
);

  // Handshake: req[i] is a level held with stable operands until req_ack[i]
  // pulses (the START cycle); rsp_valid[i] pulses once with rsp_ans/rsp_cycles.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_nxt;
  logic             last_grant;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             grant_en;
  logic             grant_idx;
  logic             finish_en;

  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

  always_comb begin
    state_nxt = state;
    grant_en  = 1'b0;
    grant_idx = last_grant;
    finish_en = 1'b0;
    unique case (state)
      IDLE: begin
        if (req != 2'b00) begin
          grant_en  = 1'b1;
          // On a tie the requester that did not win last time goes first.
          grant_idx = (req == 2'b11) ? ~last_grant : req[1];
          state_nxt = START;
        end
      end
      START: state_nxt = BUSY;
      BUSY: begin
        if (core_finished) begin
          finish_en = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      cnt        <= '0;
      core_msg   <= '0;
      core_key   <= '0;
      core_n     <= '0;
      rsp_ans    <= '0;
      rsp_cycles <= '0;
      rsp_valid  <= 2'b00;
    end else begin
      rsp_valid <= 2'b00;
      if (grant_en) begin
        owner      <= grant_idx;
        last_grant <= grant_idx;
        cnt        <= '0;
        core_msg   <= grant_idx ? req_msg1 : req_msg0;
        core_key   <= grant_idx ? req_key1 : req_key0;
        core_n     <= grant_idx ? req_n1   : req_n0;
      end else if (state == BUSY) begin
        cnt <= cnt_inc;
      end
      // cnt holds the BUSY cycles already elapsed, so the finishing cycle adds one.
      if (finish_en) begin
        rsp_ans    <= core_ans;
        rsp_cycles <= cnt_inc;
        rsp_valid  <= owner ? 2'b10 : 2'b01;
      end
    end
  end

  assign busy       = (state != IDLE);
  assign core_start = (state == START);
  assign req_ack    = (state == START) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign state_dbg  = state;

endmodule

// File: tb/tb_rsa_core_arbiter.sv
// Bench for rsa_core_arbiter: mock core, two requester drivers, a grant-order
// reference model feeding an expected-response queue, and a negedge monitor.
module tb_rsa_core_arbiter;

  localparam int KEY_W   = 256;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int E_W     = 1 + 8 + 32 + KEY_W;

  // clock / reset
  logic avm_clk = 1'b0;
  logic avm_rst = 1'b1;
  always #5 avm_clk = ~avm_clk;

  logic             req0_r = 1'b0;
  logic             req1_r = 1'b0;
  logic [1:0]       req;
  logic [KEY_W-1:0] req_msg0 = '0, req_key0 = '0, req_n0 = '0;
  logic [KEY_W-1:0] req_msg1 = '0, req_key1 = '0, req_n1 = '0;
  logic [1:0]       req_ack, rsp_valid, state_dbg;
  logic [KEY_W-1:0] rsp_ans, core_msg, core_key, core_n;
  logic [CNT_W-1:0] rsp_cycles;
  logic             busy, owner, core_start;
  logic [KEY_W-1:0] core_ans = '0;
  logic             core_finished = 1'b0;

  assign req = {req1_r, req0_r};

  rsa_core_arbiter #(.KEY_W(KEY_W), .CNT_W(CNT_W)) dut (
    .avm_clk(avm_clk), .avm_rst(avm_rst), .req(req),
    .req_msg0(req_msg0), .req_key0(req_key0), .req_n0(req_n0),
    .req_msg1(req_msg1), .req_key1(req_key1), .req_n1(req_n1),
    .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_ans(rsp_ans),
    .rsp_cycles(rsp_cycles), .busy(busy), .owner(owner),
    .core_start(core_start), .core_msg(core_msg), .core_key(core_key),
    .core_n(core_n), .core_ans(core_ans), .core_finished(core_finished),
    .state_dbg(state_dbg)
  );

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int rsp_seen = 0;
  logic [E_W-1:0]   exp_q[$];
  logic [KEY_W-1:0] op_msg[2], op_key[2], op_n[2];

  // mock core controls
  int  mc_lat = 4;
  int  cur_lat = 0;
  bit  lat_rand = 0;
  bit  spur_idle = 0;
  bit  spur_start = 0;
  bit  mc_active = 0;
  int  mc_cnt = 0;
  logic [KEY_W-1:0] mc_m, mc_k, mc_n;

  task automatic check(input string name, input logic [KEY_W-1:0] act,
                       input logic [KEY_W-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [KEY_W-1:0] mock_f(input logic [KEY_W-1:0] m,
                                               input logic [KEY_W-1:0] k,
                                               input logic [KEY_W-1:0] n);
    return (m + k) ^ n;
  endfunction

  function automatic logic [KEY_W-1:0] rand_key();
    logic [KEY_W-1:0] r;
    for (int w = 0; w < KEY_W / 32; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  // Mock core: finishes in the cur_lat-th cycle after the START cycle.
  initial begin
    forever begin
      @(posedge avm_clk); #1;
      core_finished = 1'b0;
      if (avm_rst) begin
        mc_active = 0;
      end else begin
        if (mc_active) begin
          mc_cnt++;
          if (mc_cnt == cur_lat) begin
            core_finished = 1'b1;
            core_ans = mock_f(mc_m, mc_k, mc_n);
            mc_active = 0;
          end
        end
        if (core_start) begin
          mc_active = 1;
          mc_cnt = 0;
          mc_m = core_msg; mc_k = core_key; mc_n = core_n;
          cur_lat = lat_rand ? int'($urandom_range(1, 8)) : mc_lat;
          if (spur_start) begin
            core_finished = 1'b1;
            core_ans = '1;
            spur_start = 0;
          end
        end else if (spur_idle && !mc_active && !busy) begin
          core_finished = 1'b1;
          core_ans = '1;
          spur_idle = 0;
        end
      end
    end
  end

  // Monitor + reference model: grant order from request levels, responses from queue.
  logic [1:0] prev_req = 2'b00;
  logic       last_m = 1'b1;
  logic       mon_w;
  int         expect_ack_cyc = -1;
  logic [E_W-1:0] e;
  int         e_lat, e_ack;
  initial begin
    forever begin
      @(negedge avm_clk);
      cyc++;
      if (avm_rst) begin
        exp_q.delete();
        last_m = 1'b1;
        expect_ack_cyc = -1;
        prev_req = req;
        continue;
      end
      check("ack_onehot", $countones(req_ack) <= 1, 1);
      check("start_eq_ack", core_start, req_ack != 2'b00);
      if (cyc == expect_ack_cyc) begin
        check("back_to_back_start", core_start, 1);
        expect_ack_cyc = -1;
      end
      if (req_ack != 2'b00) begin
        mon_w = (prev_req == 2'b11) ? ~last_m : prev_req[1];
        check("ack_had_req", prev_req != 2'b00, 1);
        check("ack_idx", req_ack, mon_w ? 2'b10 : 2'b01);
        check("owner", owner, mon_w);
        check("busy_in_start", busy, 1);
        check("core_msg", core_msg, op_msg[mon_w]);
        check("core_key", core_key, op_key[mon_w]);
        check("core_n", core_n, op_n[mon_w]);
        last_m = mon_w;
        exp_q.push_back({mon_w, 8'(cur_lat), 32'(cyc),
                         mock_f(op_msg[mon_w], op_key[mon_w], op_n[mon_w])});
      end
      if (rsp_valid != 2'b00) begin
        rsp_seen++;
        check("rsp_onehot", $countones(rsp_valid), 1);
        check("rsp_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          e_lat = int'(e[E_W-2 -: 8]);
          e_ack = int'(e[KEY_W+31 -: 32]);
          check("rsp_idx", rsp_valid, e[E_W-1] ? 2'b10 : 2'b01);
          check("rsp_ans", rsp_ans, e[KEY_W-1:0]);
          check("rsp_cycles", rsp_cycles, (e_lat > CNT_MAX) ? CNT_MAX : e_lat);
          check("rsp_timing", cyc, e_ack + e_lat + 1);
          check("rsp_state_idle", state_dbg, 2'd0);
        end
        if (req != 2'b00) expect_ack_cyc = cyc + 1;
      end
      prev_req = req;
    end
  end

  // driver tasks
  task automatic issue(input int i, input logic [KEY_W-1:0] m,
                       input logic [KEY_W-1:0] k, input logic [KEY_W-1:0] n);
    int t;
    @(posedge avm_clk); #1;
    op_msg[i] = m; op_key[i] = k; op_n[i] = n;
    if (i == 0) begin
      req_msg0 = m; req_key0 = k; req_n0 = n; req0_r = 1'b1;
    end else begin
      req_msg1 = m; req_key1 = k; req_n1 = n; req1_r = 1'b1;
    end
    t = 0;
    do begin
      @(negedge avm_clk);
      t++;
    end while (!req_ack[i] && t < 400);
    check("ack_wait", req_ack[i], 1);
    @(posedge avm_clk); #1;
    if (i == 0) req0_r = 1'b0;
    else req1_r = 1'b0;
  endtask

  task automatic issue_rand(input int i);
    issue(i, rand_key(), rand_key(), rand_key());
  endtask

  task automatic do_reset();
    @(posedge avm_clk); #2;
    avm_rst = 1'b1;
    repeat (3) @(posedge avm_clk);
    #2 avm_rst = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy) && t < 600) begin
      @(negedge avm_clk);
      t++;
    end
    check("drain_queue", exp_q.size(), 0);
    check("drain_idle", busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ack"}, req_ack, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_owner"}, owner, 0);
    check({tag, "_core_start"}, core_start, 0);
    check({tag, "_rsp_ans"}, rsp_ans, 0);
    check({tag, "_rsp_cycles"}, rsp_cycles, 0);
    check({tag, "_core_msg"}, core_msg, 0);
    check({tag, "_core_key"}, core_key, 0);
    check({tag, "_core_n"}, core_n, 0);
    check({tag, "_state"}, state_dbg, 0);
  endtask

  initial begin
    int seen0;
    #1;
    check_all_zero("reset");
    repeat (3) @(posedge avm_clk);
    #2 avm_rst = 1'b0;

    // single request, core finishes in BUSY cycle 5
    mc_lat = 5;
    issue(0, 256'h1234, 256'h3, 256'hFFFF);
    drain();

    // simultaneous first requests after reset
    do_reset();
    mc_lat = 4;
    fork
      issue_rand(0);
      issue_rand(1);
    join
    drain();

    // sustained contention: six alternating grants
    mc_lat = 4;
    fork
      repeat (3) issue_rand(0);
      repeat (3) issue_rand(1);
    join
    drain();

    // spurious finishes in IDLE and START
    seen0 = rsp_seen;
    spur_idle = 1;
    repeat (4) @(negedge avm_clk);
    check("spur_idle_state", state_dbg, 0);
    check("spur_idle_norsp", rsp_seen, seen0);
    spur_start = 1;
    mc_lat = 6;
    issue_rand(0);
    drain();
    check("spur_one_rsp", rsp_seen, seen0 + 1);

    // reset in BUSY cycle 3
    mc_lat = 10;
    seen0 = rsp_seen;
    issue_rand(0);
    @(posedge avm_clk);
    @(posedge avm_clk); #2;
    avm_rst = 1'b1;
    #1;
    check_all_zero("midrst");
    repeat (3) @(posedge avm_clk);
    #2 avm_rst = 1'b0;
    repeat (12) @(negedge avm_clk);
    check("midrst_norsp", rsp_seen, seen0);
    mc_lat = 3;
    issue_rand(1);
    drain();

    // counter saturation
    mc_lat = 20;
    issue_rand(1);
    drain();

    // randomized traffic
    lat_rand = 1;
    fork
      repeat (5) begin
        repeat ($urandom_range(0, 6)) @(posedge avm_clk);
        issue_rand(0);
      end
      repeat (5) begin
        repeat ($urandom_range(0, 6)) @(posedge avm_clk);
        issue_rand(1);
      end
    join
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time %0t exceeded limit", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rsa_core_arbiter.md
# rsa_core_arbiter

Shares one RSA modular-exponentiation core (start/finished handshake, KEY_W-bit message, key and modulus) between two independent requesters, e.g. the host UART wrapper and an on-chip self-test engine. Each request is latched and sequenced through the core. The result is routed back to the owning requester, together with the core's busy-cycle count. Grant order between the two requesters is round-robin.

## Interface
- KEY_W, 1024: operand and result width in bits
- CNT_W, 32: width of the busy-cycle counter
- avm_clk  in  1  clock
- avm_rst  in  1  reset, asynchronous, active-high
- req  in  2  per-requester request level; bit i = requester i
- req_msg0 / req_key0 / req_n0  in  KEY_W each  requester 0 operands; stable while req[0] high
- req_msg1 / req_key1 / req_n1  in  KEY_W each  requester 1 operands; stable while req[1] high
- req_ack  out  2  one-cycle pulse: operands of requester i latched
- rsp_valid  out  2  one-cycle pulse: result for requester i on rsp_ans
- rsp_ans  out  KEY_W  last result, held until next result
- rsp_cycles  out  CNT_W  core busy cycles of last operation, held with rsp_ans
- busy  out  1  high in START and BUSY states
- owner  out  1  index of the requester currently or last granted
- core_start  out  1  one-cycle start pulse to core
- core_msg / core_key / core_n  out  KEY_W each  latched operands, held through operation
- core_ans  in  KEY_W  core result, valid when core_finished high
- core_finished  in  1  core completion, single-cycle pulse

## Operation
- States:
  - IDLE: accept a request.
  - START: core_start=1 and req_ack[owner]=1 for exactly this cycle.
  - BUSY: wait for core_finished.
- All outputs are registers or decodes of state/registers. No combinational path from inputs to outputs.
- IDLE, req != 0:
  - Only one bit set: grant that requester.
  - Both bits set: grant !last_grant.
  - Grant cycle: latch the granted operands into core_msg/key/n, set owner and last_grant to the granted index, clear cycle counter, next state START.
- IDLE, req == 0: stay in IDLE. core_finished is ignored in IDLE.
- START: always goes to BUSY next. core_finished is ignored in START.
- BUSY: the cycle counter increments every cycle, saturating at 2^CNT_W-1.
- BUSY, core_finished=1:
  - Latch core_ans into rsp_ans.
  - Latch counter+1 (saturating) into rsp_cycles.
  - rsp_valid[owner]=1 in the next cycle.
  - Next state IDLE.
- Requesters must drop req within one cycle of req_ack.
  - req still high when the arbiter re-enters IDLE is treated as a new request.
  - Round-robin still applies if both are high.
- Requests arriving while busy wait. They are never dropped or acknowledged early.
- Reset values:
  - state IDLE, last_grant=1, so requester 0 wins the first tie.
  - owner=0, busy=0, req_ack=0, rsp_valid=0, core_start=0.
  - rsp_ans=0, rsp_cycles=0, core_msg/key/n=0, counter=0.
- Reset mid-operation:
  - Aborts immediately with no rsp_valid.
  - The core shares avm_rst, so no stale core_finished is expected.

## Timing
- Cycle numbering (T = cycle in which IDLE samples req):
  - T+1: START; req_ack and core_start high, busy=1.
  - T+2 onwards: BUSY.
- core_finished in BUSY cycle k (first BUSY cycle is k=1): rsp_valid and rsp_ans/rsp_cycles=k in the following cycle. That cycle is IDLE.
- New grant sampling happens in that same IDLE cycle, so the next START can occur one cycle after rsp_valid.
- Minimum request-to-response latency: 3 cycles plus core latency.
- Fixed relationships:
  - At most one bit of req_ack and of rsp_valid is high in any cycle.
  - core_start is never high while busy from a previous grant.

## Test plan
- Single request: KEY_W=256, mock core finishes in BUSY cycle 5. Pulse req[0] with msg=0x1234, key=0x3, n=0xFFFF.
  - Expected: req_ack[0] at T+1; core_start at T+1 only; rsp_valid[0] at T+7; rsp_ans=mock result; rsp_cycles=5; rsp_valid[1] never.
- Simultaneous first requests: req=2'b11 right after reset.
  - Expected: requester 0 acknowledged first, requester 1 second with core_msg=req_msg1.
  - Expected: owner sequence 0,1; two rsp_valid pulses, in order 0 then 1.
- Sustained contention: both req held high for 6 operations.
  - Expected: grants alternate 0,1,0,1,0,1; each START exactly one cycle after the previous rsp_valid.
- Spurious finish: core_finished pulsed in IDLE and in START.
  - Expected: no rsp_valid, no state change; the operation completes only on the later BUSY finish.
- Reset mid-operation: assert avm_rst in BUSY cycle 3.
  - Expected: all outputs 0 and busy=0 immediately, no rsp_valid.
  - Expected: after release, a req[1]-only request is granted normally.
- Counter saturation: CNT_W=4, mock core finishes in BUSY cycle 20.
  - Expected: rsp_cycles=15.
